// File: rtl/response_picker.sv
// Reply picker between the command decoder and the word-bank ROM.
// When a request carries the selecting op_code, the picker draws word-bank indices
// from a free-running LFSR until it finds one that differs from the user's word.
// With NO_REPEAT set, the index must also differ from the previous reply.
// If MAX_RETRY draws are rejected, it emits a deterministic fallback index instead,
// so the reply latency stays bounded.
module response_picker #(
   parameter int unsigned          NUM_WORDS  = 7,
   parameter int unsigned          IDX_W      = 3,
   parameter int unsigned          OPCODE_W   = 11,
   parameter logic [OPCODE_W-1:0]  OPCODE_SEL = 11'b00000100000,
   parameter bit                   NO_REPEAT  = 1'b1,
   parameter logic [15:0]          LFSR_SEED  = 16'hACE1,
   parameter int unsigned          MAX_RETRY  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OPCODE_W-1:0] op_code,
   input  logic [IDX_W-1:0]    in_idx,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [IDX_W-1:0]    out_idx,
   output logic                out_fallbk
);

   localparam int unsigned      RETRY_W    = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
   localparam logic [IDX_W-1:0] NUM_IDX    = IDX_W'(NUM_WORDS);
   localparam logic [IDX_W-1:0] TOP_IDX    = IDX_W'(NUM_WORDS - 1);
   localparam logic [IDX_W-1:0] NONE_IDX   = '1;
   localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
   localparam logic [15:0]      LFSR_TAPS  = 16'hB400;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      HOLD = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [IDX_W-1:0]   ex_idx_q, ex_idx_d;
   logic [IDX_W-1:0]   last_idx_q, last_idx_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic [IDX_W-1:0]   out_idx_q, out_idx_d;
   logic               out_fallbk_q, out_fallbk_d;

   logic [IDX_W-1:0]   cand;
   logic               cand_reject;
   logic [IDX_W-1:0]   fb_first, fb_step, fb_idx;

   // Increment modulo NUM_WORDS for in-range bank indices.
   function automatic logic [IDX_W-1:0] inc_mod(input logic [IDX_W-1:0] v);
      return (v == TOP_IDX) ? '0 : v + IDX_W'(1);
   endfunction

   // Galois LFSR step; it runs every cycle regardless of FSM state.
   always_comb begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
   end

   // Candidate filtering and the deterministic fallback choice.
   always_comb begin
      cand        = lfsr_q[IDX_W-1:0];
      cand_reject = (cand >= NUM_IDX) || (cand == ex_idx_q) ||
                    (NO_REPEAT && (cand == last_idx_q));
      // An out-of-range user word excludes nothing, so start the fallback at entry 0.
      fb_first    = (ex_idx_q < NUM_IDX) ? inc_mod(ex_idx_q) : '0;
      fb_step     = inc_mod(fb_first);
      fb_idx      = fb_first;
      if (NO_REPEAT && (fb_first == last_idx_q)) begin
         fb_idx = (fb_step == ex_idx_q) ? inc_mod(fb_step) : fb_step;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
      end
   end

   // Datapath registers; every register gets a reset value, so a reset aborts a pending reply cleanly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q       <= LFSR_SEED;
         ex_idx_q     <= NONE_IDX;
         last_idx_q   <= NONE_IDX;
         retry_q      <= '0;
         out_idx_q    <= '0;
         out_fallbk_q <= 1'b0;
      end else begin
         lfsr_q       <= lfsr_d;
         ex_idx_q     <= ex_idx_d;
         last_idx_q   <= last_idx_d;
         retry_q      <= retry_d;
         out_idx_q    <= out_idx_d;
         out_fallbk_q <= out_fallbk_d;
      end
   end

   // Next-state and datapath update logic.
   always_comb begin
      // NOTE: every _d holds its value by default, so no branch can infer a latch.
      state_d      = state_q;
      ex_idx_d     = ex_idx_q;
      last_idx_d   = last_idx_q;
      retry_d      = retry_q;
      out_idx_d    = out_idx_q;
      out_fallbk_d = out_fallbk_q;
      unique case (state_q)
         IDLE: begin
            // A request with another op_code is consumed and dropped.
            if (in_valid && (op_code == OPCODE_SEL)) begin
               ex_idx_d = in_idx;
               retry_d  = '0;
               state_d  = DRAW;
            end
         end
         DRAW: begin
            if (!cand_reject) begin
               out_idx_d    = cand;
               out_fallbk_d = 1'b0;
               state_d      = HOLD;
            end else if (retry_q == RETRY_LAST) begin
               out_idx_d    = fb_idx;
               out_fallbk_d = 1'b1;
               state_d      = HOLD;
            end else begin
               retry_d = retry_q + RETRY_W'(1);
            end
         end
         HOLD: begin
            if (out_ready) begin
               last_idx_d = out_idx_q;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decode straight from the state register (no comb path from out_ready).
   always_comb begin
      in_ready   = (state_q == IDLE);
      out_valid  = (state_q == HOLD);
      out_idx    = out_idx_q;
      out_fallbk = out_fallbk_q;
   end

endmodule
